// File: rtl/fpmul_share_ctrl.sv
// Round-robin front end for one free-running serial FP32 multiplier shared by NREQ requesters.
// Operands go out on mul_a in lock-step with the multiplier phase; products land in a 2-entry FIFO.
module fpmul_share_ctrl #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_product,
  output logic [31:0]          mul_a,
  input  logic                 mul_ready,
  input  logic [31:0]          mul_product,
  output logic                 busy,
  output logic                 sync_err
);

  typedef enum logic [1:0] {IDLE, OPA, OPB, RESULT} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic            sync_err_q, sync_err_d;
  logic [IDW-1:0]  mid_q [2];
  logic [IDW-1:0]  mid_d [2];
  logic [31:0]     mp_q [2];
  logic [31:0]     mp_d [2];
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [1:0]      cnt_q, cnt_d;

  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];
  logic            found, grant, pop, push, credit_ok;
  logic [IDW-1:0]  win, idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*32 +: 32];
    assign b_arr[g] = req_b[g*32 +: 32];
  end

  // Arbitration and credit: a grant reserves a FIFO slot three cycles ahead.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    push      = (state_q == RESULT);
    pop       = (cnt_q != 2'd0) && resp_ready;
    credit_ok = ({1'b0, cnt_q} + {2'b0, push}) <= (3'd1 + {2'b0, pop});
    grant     = ((state_q == IDLE) || (state_q == RESULT)) && mul_ready && found && credit_ok;
    req_ready = grant ? (NREQ'(1) << win) : '0;
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    b_d        = b_q;
    mul_a_d    = '0;
    sync_err_d = sync_err_q;
    mid_d      = mid_q;
    mp_d       = mp_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q + 2'(push) - 2'(pop);
    case (state_q)
      IDLE:   if (grant) state_d = OPA;
      OPA:    begin state_d = OPB; mul_a_d = b_q; end
      OPB:    state_d = RESULT;
      RESULT: begin
        // A missing ready here means we drifted out of phase; still capture and carry on.
        if (!mul_ready) sync_err_d = 1'b1;
        state_d = grant ? OPA : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      mul_a_d = a_arr[win];
      b_d     = b_arr[win];
      id_d    = win;
      rr_d    = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end
    if (push) begin
      mid_d[wr_q] = id_q;
      mp_d[wr_q]  = mul_product;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      b_q        <= '0;
      mul_a_q    <= '0;
      sync_err_q <= 1'b0;
      mid_q      <= '{default: '0};
      mp_q       <= '{default: '0};
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      b_q        <= b_d;
      mul_a_q    <= mul_a_d;
      sync_err_q <= sync_err_d;
      mid_q      <= mid_d;
      mp_q       <= mp_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign resp_valid   = (cnt_q != 2'd0);
  assign resp_id      = resp_valid ? mid_q[rd_q] : '0;
  assign resp_product = resp_valid ? mp_q[rd_q] : '0;
  assign mul_a        = mul_a_q;
  assign busy         = (state_q != IDLE);
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// Bench for fpmul_share_ctrl: behavioural serial multiplier plus an in-order response scoreboard.
module tb_fpmul_share_ctrl;
  localparam int NREQ = 4;

  logic              clock = 1'b0;
  logic              nreset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [1:0]        resp_id;
  logic [31:0]       resp_product;
  logic [31:0]       mul_a;
  logic              mul_ready;
  logic [31:0]       mul_product;
  logic              busy;
  logic              sync_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct { logic [1:0] id; logic [31:0] p; } exp_t;
  exp_t sb[$];
  int   gq[$];
  int   gc[$];

  fpmul_share_ctrl #(.NREQ(NREQ)) dut (
    .clock(clock), .nreset(nreset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .mul_a(mul_a), .mul_ready(mul_ready),
    .mul_product(mul_product), .busy(busy), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  // Stand-in multiplier: known vectors give true IEEE products, others a fixed scramble.
  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'hC0000000) return 32'hC0400000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
  endfunction

  logic [1:0]  ph;
  logic [31:0] m_opa, m_prod;
  logic        kill = 1'b0;
  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ph <= 2'd0; m_opa <= '0; m_prod <= '0;
    end else begin
      ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
      if (ph == 2'd1) m_opa <= mul_a;
      if (ph == 2'd2) m_prod <= fmul(m_opa, mul_a);
    end
  end
  assign mul_ready   = (ph == 2'd0) && !kill;
  assign mul_product = m_prod;

  // Response monitor: every pop must match the oldest expected result.
  always @(negedge clock) begin
    if (nreset && resp_valid && resp_ready) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL resp_unexpected: got id %0d product %h, want no response", resp_id, resp_product);
      end else begin
        if (resp_id !== sb[0].id || resp_product !== sb[0].p)
          $display("FAIL resp_data: got id %0d product %h, want id %0d product %h",
                   resp_id, resp_product, sb[0].id, sb[0].p);
        else pass_cnt++;
        void'(sb.pop_front());
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input bit exp);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i] = 1'b1;
    if (exp) sb.push_back('{id: 2'(i), p: fmul(a, b)});
  endtask

  task automatic do_reset();
    nreset = 1'b0; req_valid = '0; resp_ready = 1'b1; kill = 1'b0;
    sb.delete(); gq.delete(); gc.delete();
    repeat (2) @(posedge clock);
    #1 nreset = 1'b1;
  endtask

  // Runs n cycles, logging grants and withdrawing each granted request after its edge.
  task automatic run_cycles(input int n);
    logic [NREQ-1:0] g;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      g = req_ready;
      if (g != 0) begin
        chk_cnt++;
        if (!$onehot(g)) $display("FAIL grant_onehot: got %b, want one-hot", g);
        else pass_cnt++;
        for (int i = 0; i < NREQ; i++) if (g[i]) begin gq.push_back(i); gc.push_back(c); end
      end
      @(posedge clock);
      #1 req_valid = req_valid & ~g;
    end
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g);
    g = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (req_ready != 0) begin g = req_ready; break; end
    end
    chk_cnt++;
    if (g == 0) $display("FAIL grant_timeout: got no req_ready, want a grant");
    else pass_cnt++;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0 && !resp_valid) break;
      @(posedge clock);
      #1;
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL drain: got %0d responses outstanding, want 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    nreset = 1'b0; req_valid = '0;
    @(negedge clock);
    chk_cnt++;
    if ({req_ready, resp_valid, resp_id, resp_product, mul_a, busy, sync_err} !== '0)
      $display("FAIL reset_outputs: got %b/%b/%0d/%h/%h/%b/%b, want all zero",
               req_ready, resp_valid, resp_id, resp_product, mul_a, busy, sync_err);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g;
    do_reset();
    set_req(0, 32'h40000000, 32'h40400000, 1'b1);
    wait_grant(g);
    chk_cnt++;
    if (g !== 4'b0001) $display("FAIL single_grant: got %b, want 0001", g); else pass_cnt++;
    @(posedge clock); #1 req_valid = '0;
    @(negedge clock);
    chk_cnt++;
    if (mul_a !== 32'h40000000 || !busy) $display("FAIL single_opa: got %h busy %b, want 40000000 busy 1", mul_a, busy);
    else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if (mul_a !== 32'h40400000) $display("FAIL single_opb: got %h, want 40400000", mul_a); else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if (mul_a !== 32'h0 || resp_valid) $display("FAIL single_result: got %h valid %b, want 0 valid 0", mul_a, resp_valid);
    else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if (!resp_valid || resp_id !== 2'd0 || resp_product !== 32'h40C00000)
      $display("FAIL single_resp: got valid %b id %0d product %h, want 1 0 40c00000", resp_valid, resp_id, resp_product);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_all();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h3FC00000, 32'hC0000000, 1'b1);
    run_cycles(16);
    chk_cnt++;
    if (gq.size() != 4 || gq[0] != 0 || gq[1] != 1 || gq[2] != 2 || gq[3] != 3)
      $display("FAIL all_order: got %0d grants %p, want 0,1,2,3", gq.size(), gq);
    else pass_cnt++;
    chk_cnt++;
    if (gc.size() != 4 || gc[1] - gc[0] != 3 || gc[2] - gc[1] != 3 || gc[3] - gc[2] != 3)
      $display("FAIL all_spacing: got cycles %p, want spacing 3", gc);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_credit();
    do_reset();
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h11110000 + 32'(i), 32'h00002222 * 32'(i + 1), 1'b1);
    run_cycles(30);
    chk_cnt++;
    if (gq.size() != 2) $display("FAIL credit_block: got %0d grants, want 2", gq.size()); else pass_cnt++;
    chk_cnt++;
    if (!resp_valid || sb.size() != 4) $display("FAIL credit_hold: got valid %b outstanding %0d, want 1 4", resp_valid, sb.size());
    else pass_cnt++;
    resp_ready = 1'b1;
    run_cycles(30);
    chk_cnt++;
    if (gq.size() != 4 || gq[2] != 2 || gq[3] != 3) $display("FAIL credit_resume: got %p, want 0,1,2,3", gq);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_rr();
    do_reset();
    set_req(2, 32'h7FC00001, 32'h7F800000, 1'b1);
    run_cycles(6);
    set_req(2, 32'h00000001, 32'h80000001, 1'b0);
    set_req(3, 32'hFF800000, 32'h3F800000, 1'b1);
    sb.push_back('{id: 2'd2, p: fmul(32'h00000001, 32'h80000001)});
    run_cycles(12);
    chk_cnt++;
    if (gq.size() != 3 || gq[0] != 2 || gq[1] != 3 || gq[2] != 2) $display("FAIL rr_order: got %p, want 2,3,2", gq);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g;
    do_reset();
    set_req(0, 32'h40000000, 32'h40400000, 1'b0);
    wait_grant(g);
    @(posedge clock); #1 req_valid = '0;
    @(posedge clock); #1 nreset = 1'b0;
    #1;
    chk_cnt++;
    if ({req_ready, resp_valid, resp_id, resp_product, mul_a, busy, sync_err} !== '0)
      $display("FAIL midreset_outputs: got mul_a %h busy %b valid %b, want all zero", mul_a, busy, resp_valid);
    else pass_cnt++;
    repeat (2) @(posedge clock);
    #1 nreset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk_cnt++;
    if (resp_valid || busy) $display("FAIL midreset_discard: got valid %b busy %b, want 0 0", resp_valid, busy);
    else pass_cnt++;
    set_req(1, 32'h3FC00000, 32'hC0000000, 1'b1);
    run_cycles(8);
    drain();
    chk_cnt++;
    if (sync_err !== 1'b0) $display("FAIL midreset_sync: got %b, want 0", sync_err); else pass_cnt++;
  endtask

  task automatic test_sync();
    logic [NREQ-1:0] g;
    do_reset();
    set_req(0, 32'h40000000, 32'h40400000, 1'b1);
    wait_grant(g);
    @(posedge clock); #1 req_valid = '0;
    @(posedge clock); #1;
    @(posedge clock); #1 kill = 1'b1;
    chk_cnt++;
    if (sync_err !== 1'b0) $display("FAIL sync_early: got %b, want 0", sync_err); else pass_cnt++;
    @(posedge clock); #1 kill = 1'b0;
    chk_cnt++;
    if (sync_err !== 1'b1) $display("FAIL sync_set: got %b, want 1", sync_err); else pass_cnt++;
    drain();
    repeat (10) @(posedge clock);
    #1;
    chk_cnt++;
    if (sync_err !== 1'b1) $display("FAIL sync_sticky: got %b, want 1", sync_err); else pass_cnt++;
    nreset = 1'b0;
    #1;
    chk_cnt++;
    if (sync_err !== 1'b0) $display("FAIL sync_clear: got %b, want 0", sync_err); else pass_cnt++;
    @(posedge clock); #1 nreset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_credit();
    test_rr();
    test_reset_mid();
    test_sync();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
